ldr_str_unit: RTL

Load/store unit sitting between the datapath and data memory, directly upstream of the register file's load write port. Accepts one load or store command at a time from the controller, runs a req/ack transaction to data memory with byte-lane handling and a timeout, and returns loaded data as a single-cycle write on the regfile's `w_data_ldr`/`w_addr_ldr`/`w_en_ldr` port. It reports completion and faults back to the controller.

---
 rtl/ldr_str_unit_if.sv | 31 +++
 rtl/ldr_str_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ldr_str_unit_if.sv
// Data-memory bus between the load/store unit and memory.
// Single outstanding req/ack transaction, ack is a one-cycle pulse.
interface ldr_str_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/ldr_str_unit.sv
// Load/store unit: one command at a time, req/ack to data memory
// with byte lanes and timeout, load data written back to regfile.
module ldr_str_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_byte,
  input  logic [31:0] addr,
  input  logic [31:0] str_data,
  input  logic [3:0]  dest_reg,
  output logic        busy,
  output logic        done,
  output logic        fault,
  ldr_str_unit_if.master mem,
  output logic [31:0] w_data_ldr,
  output logic [3:0]  w_addr_ldr,
  output logic        w_en_ldr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ld_q, ld_d;
  logic        byte_q, byte_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  dest_q, dest_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  wa_q, wa_d;
  logic        wen_q, wen_d;

  logic        reject;
  logic [31:0] ldata;

  assign reject = (!is_byte && addr[1:0] != 2'b00)
               || (is_load && dest_reg == 4'hF);

  // Byte loads pick the lane and zero-extend.
  always_comb begin
    ldata = mem.mem_rdata;
    if (byte_q) begin
      unique case (lane_q)
        2'd0: ldata = {24'b0, mem.mem_rdata[7:0]};
        2'd1: ldata = {24'b0, mem.mem_rdata[15:8]};
        2'd2: ldata = {24'b0, mem.mem_rdata[23:16]};
        2'd3: ldata = {24'b0, mem.mem_rdata[31:24]};
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
    dest_d  = dest_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wd_d    = wd_q;
    wa_d    = wa_q;
    wen_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ld_d   = is_load;
          byte_d = is_byte;
          lane_d = addr[1:0];
          dest_d = dest_reg;
          busy_d = 1'b1;
          if (reject) begin
            state_d = RESP;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = !is_load;
            maddr_d = {addr[31:2], 2'b00};
            if (is_load) begin
              be_d    = 4'hF;
              wdata_d = 32'h0;
            end else if (is_byte) begin
              be_d    = 4'b0001 << addr[1:0];
              wdata_d = {4{str_data[7:0]}};
            end else begin
              be_d    = 4'hF;
              wdata_d = str_data;
            end
          end
        end
      end
      REQ: begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem.mem_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (ld_q) begin
            wen_d = 1'b1;
            wa_d  = dest_q;
            wd_d  = ldata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          req_d   = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ld_q    <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= 2'd0;
      dest_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      wd_q    <= 32'h0;
      wa_q    <= 4'h0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
      dest_q  <= dest_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
      wen_q   <= wen_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign w_data_ldr    = wd_q;
  assign w_addr_ldr    = wa_q;
  assign w_en_ldr      = wen_q;

endmodule
